// File: rtl/imem_loader.sv
// imem_loader: receives a byte stream over a valid/ready link and writes it
// into instruction memory while holding the core in reset.
// Stream layout: 4-byte little-endian word count N, then N little-endian
// 4-byte words. The optional trailing checksum (sum mod 2^32 of the data
// words) is compiled in when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  byte_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_waddr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  core_hold,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   words_loaded
);

    // Largest legal word count (the full memory depth), at header width.
    localparam logic [DATA_WIDTH-1:0] DEPTH_W =
        {{(DATA_WIDTH-ADDR_WIDTH-1){1'b0}}, 1'b1, {ADDR_WIDTH{1'b0}}};

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HDR   = 3'd1,
        DATA  = 3'd2,
        WRITE = 3'd3,
        CSUM  = 3'd4,
        DONE  = 3'd5,
        ERR   = 3'd6
    } state_t;

    state_t                state_r;
    logic [1:0]            byte_cnt_r;
    // Holds the first three bytes of the word being assembled; the fourth
    // byte is combined straight from byte_data so the word is ready on the
    // accepting cycle.
    logic [DATA_WIDTH-9:0] word_r;
    logic [ADDR_WIDTH:0]   n_r;
    logic                  byte_ready_r;
    logic                  mem_we_r;
    logic [ADDR_WIDTH-1:0] mem_waddr_r;
    logic [DATA_WIDTH-1:0] mem_wdata_r;
    logic                  core_hold_r;
    logic                  done_r;
    logic                  error_r;
    logic [ADDR_WIDTH:0]   words_loaded_r;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] csum_r;
`endif

    logic                  xfer_s;
    logic                  last_byte_s;
    logic [DATA_WIDTH-1:0] word_s;
    logic                  hdr_zero_s;
    logic                  hdr_big_s;
    logic [ADDR_WIDTH:0]   wl_next_s;
    logic                  more_s;

    assign xfer_s      = byte_valid & byte_ready_r;
    assign last_byte_s = (byte_cnt_r == 2'd3);
    assign word_s      = {byte_data, word_r};
    assign hdr_zero_s  = (word_s == {DATA_WIDTH{1'b0}});
    assign hdr_big_s   = (word_s > DEPTH_W);
    assign wl_next_s   = words_loaded_r + {{ADDR_WIDTH{1'b0}}, 1'b1};
    assign more_s      = (wl_next_s < n_r);

    // Loader FSM: byte assembly, memory write strobe, session status outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r        <= IDLE;
            byte_cnt_r     <= 2'd0;
            word_r         <= {(DATA_WIDTH-8){1'b0}};
            n_r            <= {(ADDR_WIDTH+1){1'b0}};
            byte_ready_r   <= 1'b0;
            mem_we_r       <= 1'b0;
            mem_waddr_r    <= {ADDR_WIDTH{1'b0}};
            mem_wdata_r    <= {DATA_WIDTH{1'b0}};
            core_hold_r    <= 1'b1;
            done_r         <= 1'b0;
            error_r        <= 1'b0;
            words_loaded_r <= {(ADDR_WIDTH+1){1'b0}};
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_r         <= {DATA_WIDTH{1'b0}};
`endif
        end else begin
            case (state_r)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        state_r        <= HDR;
                        byte_cnt_r     <= 2'd0;
                        word_r         <= {(DATA_WIDTH-8){1'b0}};
                        words_loaded_r <= {(ADDR_WIDTH+1){1'b0}};
                        done_r         <= 1'b0;
                        error_r        <= 1'b0;
                        core_hold_r    <= 1'b1;
                        byte_ready_r   <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum_r         <= {DATA_WIDTH{1'b0}};
`endif
                    end else if (state_r == DONE) begin
                        // Release the core one cycle after completion.
                        core_hold_r <= 1'b0;
                    end else begin
                        core_hold_r <= core_hold_r;
                    end
                end
                HDR: begin
                    if (xfer_s) begin
                        word_r     <= word_s[DATA_WIDTH-1:8];
                        byte_cnt_r <= byte_cnt_r + 2'd1;
                        if (last_byte_s) begin
                            if (hdr_zero_s) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                                state_r      <= CSUM;
`else
                                state_r      <= DONE;
                                done_r       <= 1'b1;
                                byte_ready_r <= 1'b0;
`endif
                            end else if (hdr_big_s) begin
                                state_r      <= ERR;
                                error_r      <= 1'b1;
                                byte_ready_r <= 1'b0;
                            end else begin
                                state_r <= DATA;
                                n_r     <= word_s[ADDR_WIDTH:0];
                            end
                        end
                    end
                end
                DATA: begin
                    if (xfer_s) begin
                        word_r     <= word_s[DATA_WIDTH-1:8];
                        byte_cnt_r <= byte_cnt_r + 2'd1;
                        if (last_byte_s) begin
                            state_r      <= WRITE;
                            byte_ready_r <= 1'b0;
                            mem_we_r     <= 1'b1;
                            mem_waddr_r  <= words_loaded_r[ADDR_WIDTH-1:0];
                            mem_wdata_r  <= word_s;
`ifdef IMEM_LOADER_CHECKSUM_EN
                            csum_r       <= csum_r + word_s;
`endif
                        end
                    end
                end
                WRITE: begin
                    mem_we_r       <= 1'b0;
                    words_loaded_r <= wl_next_s;
                    if (more_s) begin
                        state_r      <= DATA;
                        byte_ready_r <= 1'b1;
                    end else begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_r      <= CSUM;
                        byte_ready_r <= 1'b1;
`else
                        state_r      <= DONE;
                        done_r       <= 1'b1;
`endif
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                CSUM: begin
                    if (xfer_s) begin
                        word_r     <= word_s[DATA_WIDTH-1:8];
                        byte_cnt_r <= byte_cnt_r + 2'd1;
                        if (last_byte_s) begin
                            byte_ready_r <= 1'b0;
                            if (word_s == csum_r) begin
                                state_r <= DONE;
                                done_r  <= 1'b1;
                            end else begin
                                state_r <= ERR;
                                error_r <= 1'b1;
                            end
                        end
                    end
                end
`endif
                default: begin
                    state_r      <= IDLE;
                    byte_ready_r <= 1'b0;
                    mem_we_r     <= 1'b0;
                    done_r       <= 1'b0;
                    error_r      <= 1'b0;
                    core_hold_r  <= 1'b1;
                end
            endcase
        end
    end

    assign byte_ready   = byte_ready_r;
    assign mem_we       = mem_we_r;
    assign mem_waddr    = mem_waddr_r;
    assign mem_wdata    = mem_wdata_r;
    assign core_hold    = core_hold_r;
    assign done         = done_r;
    assign error        = error_r;
    assign words_loaded = words_loaded_r;

endmodule

// File: tb/tb_imem_loader.sv
// Directed testbench for imem_loader; works with or without
// IMEM_LOADER_CHECKSUM_EN (checksum bytes are sent only when it is defined).
module tb_imem_loader;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic        byte_ready;
    logic        mem_we;
    logic [11:0] mem_waddr;
    logic [31:0] mem_wdata;
    logic        core_hold;
    logic        done;
    logic        error;
    logic [12:0] words_loaded;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem_model [0:4095];
    int          write_count = 0;
    int          addr0_writes = 0;
    logic [11:0] last_waddr = 12'd0;

    imem_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(12)) dut (
        .clock(clock), .reset(reset), .start(start),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .core_hold(core_hold), .done(done), .error(error),
        .words_loaded(words_loaded)
    );

    always #5 clock = ~clock;

    // Memory model: capture every write strobe seen at a rising edge.
    always @(posedge clock) begin
        if (mem_we === 1'b1) begin
            checks++;
            if (core_hold !== 1'b1) begin
                errors++;
                $display("FAIL we_while_hold: core_hold=%b required 1", core_hold);
            end
            mem_model[mem_waddr] = mem_wdata;
            write_count++;
            if (mem_waddr == 12'd0) addr0_writes++;
            last_waddr = mem_waddr;
        end
    end

    task automatic clear_model();
        write_count  = 0;
        addr0_writes = 0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        n = 0;
        repeat (gap) begin @(posedge clock); #1; end
        byte_valid = 1'b1;
        byte_data  = b;
        while (byte_ready !== 1'b1 && n < 50) begin
            @(posedge clock); #1;
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL byte_timeout: byte_ready=%b required 1", byte_ready);
        end
        @(posedge clock); #1;
        byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        send_byte(w[7:0], gap);
        send_byte(w[15:8], gap);
        send_byte(w[23:16], gap);
        send_byte(w[31:24], gap);
    endtask

    task automatic wait_final();
        int n;
        n = 0;
        while (done !== 1'b1 && error !== 1'b1 && n < 50) begin
            @(posedge clock); #1;
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL final_timeout: done=%b error=%b required one high", done, error);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        checks++; if (byte_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b want 0", byte_ready); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_we: got %b want 0", mem_we); end
        checks++; if (mem_waddr !== 12'd0) begin errors++; $display("FAIL rst_waddr: got %h want 000", mem_waddr); end
        checks++; if (mem_wdata !== 32'd0) begin errors++; $display("FAIL rst_wdata: got %h want 0", mem_wdata); end
        checks++; if (done !== 1'b0 || error !== 1'b0) begin errors++; $display("FAIL rst_status: done=%b error=%b want 0 0", done, error); end
        checks++; if (words_loaded !== 13'd0) begin errors++; $display("FAIL rst_count: got %0d want 0", words_loaded); end
        checks++; if (core_hold !== 1'b1) begin errors++; $display("FAIL rst_hold: got %b want 1", core_hold); end
    endtask

    task automatic test_basic();
        clear_model();
        pulse_start();
        checks++; if (byte_ready !== 1'b1) begin errors++; $display("FAIL basic_ready: got %b want 1", byte_ready); end
        send_word(32'h0000_0002, 0);
        pulse_start();  // must be ignored mid-session
        send_word(32'h0000_0013, 0);
        send_word(32'h0010_0093, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_word(32'h0010_00A6, 0);
`endif
        wait_final();
        checks++; if (done !== 1'b1 || error !== 1'b0) begin errors++; $display("FAIL basic_done: done=%b error=%b want 1 0", done, error); end
        checks++; if (core_hold !== 1'b1) begin errors++; $display("FAIL basic_hold_first: got %b want 1", core_hold); end
        checks++; if (write_count != 2) begin errors++; $display("FAIL basic_writes: got %0d want 2", write_count); end
        checks++; if (mem_model[0] !== 32'h0000_0013) begin errors++; $display("FAIL basic_addr0: got %h want 00000013", mem_model[0]); end
        checks++; if (mem_model[1] !== 32'h0010_0093) begin errors++; $display("FAIL basic_addr1: got %h want 00100093", mem_model[1]); end
        checks++; if (words_loaded !== 13'd2) begin errors++; $display("FAIL basic_count: got %0d want 2", words_loaded); end
        checks++; if (mem_waddr !== 12'd1 || mem_wdata !== 32'h0010_0093) begin errors++; $display("FAIL basic_hold_bus: addr=%h data=%h want 001 00100093", mem_waddr, mem_wdata); end
        @(posedge clock); #1;
        checks++; if (core_hold !== 1'b0) begin errors++; $display("FAIL basic_hold_drop: got %b want 0", core_hold); end
        checks++; if (done !== 1'b1 || byte_ready !== 1'b0) begin errors++; $display("FAIL basic_done_level: done=%b ready=%b want 1 0", done, byte_ready); end
    endtask

    task automatic test_zero();
        clear_model();
        pulse_start();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL zero_clear: done=%b want 0", done); end
        send_word(32'h0000_0000, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_word(32'h0000_0000, 0);
`endif
        wait_final();
        checks++; if (done !== 1'b1 || error !== 1'b0) begin errors++; $display("FAIL zero_done: done=%b error=%b want 1 0", done, error); end
        checks++; if (write_count != 0) begin errors++; $display("FAIL zero_writes: got %0d want 0", write_count); end
        checks++; if (words_loaded !== 13'd0) begin errors++; $display("FAIL zero_count: got %0d want 0", words_loaded); end
    endtask

    task automatic test_overflow();
        clear_model();
        pulse_start();
        send_word(32'h0000_1001, 0);
        wait_final();
        repeat (2) @(posedge clock);
        #1;
        checks++; if (error !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL ovf_error: error=%b done=%b want 1 0", error, done); end
        checks++; if (core_hold !== 1'b1) begin errors++; $display("FAIL ovf_hold: got %b want 1", core_hold); end
        checks++; if (write_count != 0) begin errors++; $display("FAIL ovf_writes: got %0d want 0", write_count); end
        checks++; if (byte_ready !== 1'b0) begin errors++; $display("FAIL ovf_ready: got %b want 0", byte_ready); end
        pulse_start();
        checks++; if (error !== 1'b0 || byte_ready !== 1'b1) begin errors++; $display("FAIL ovf_restart: error=%b ready=%b want 0 1", error, byte_ready); end
        send_word(32'h0000_0001, 0);
        send_word(32'h0000_0013, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_word(32'h0000_0013, 0);
`endif
        wait_final();
        checks++; if (done !== 1'b1 || write_count != 1 || mem_model[0] !== 32'h0000_0013) begin
            errors++; $display("FAIL ovf_reload: done=%b writes=%0d data=%h want 1 1 00000013", done, write_count, mem_model[0]);
        end
    endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        pulse_start();
        send_word(32'h0000_0001, 0);
        send_word(32'h0000_0013, 0);
        send_word(32'h0000_0014, 0);
        wait_final();
        checks++; if (error !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL csum_bad: error=%b done=%b want 1 0", error, done); end
        pulse_start();
        send_word(32'h0000_0001, 0);
        send_word(32'h0000_0013, 0);
        send_word(32'h0000_0013, 0);
        wait_final();
        checks++; if (done !== 1'b1 || error !== 1'b0) begin errors++; $display("FAIL csum_good: done=%b error=%b want 1 0", done, error); end
    endtask
`endif

    task automatic test_reset_mid();
        logic [31:0] sum;
        clear_model();
        pulse_start();
        send_word(32'h0000_0005, $urandom_range(0, 3));
        for (int i = 0; i < 3; i++) send_word(32'hDEAD_0000 + 32'(i), $urandom_range(0, 3));
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        checks++; if (write_count != 3) begin errors++; $display("FAIL mid_writes: got %0d want 3", write_count); end
        checks++; if (byte_ready !== 1'b0 || words_loaded !== 13'd0 || core_hold !== 1'b1) begin
            errors++; $display("FAIL mid_idle: ready=%b count=%0d hold=%b want 0 0 1", byte_ready, words_loaded, core_hold);
        end
        clear_model();
        sum = 32'd0;
        pulse_start();
        send_word(32'h0000_0005, $urandom_range(0, 3));
        for (int i = 0; i < 5; i++) begin
            send_word(32'h1234_5000 + 32'(i * 7), $urandom_range(0, 3));
            sum = sum + 32'h1234_5000 + 32'(i * 7);
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_word(sum, 1);
`endif
        wait_final();
        checks++; if (done !== 1'b1 || write_count != 5 || words_loaded !== 13'd5) begin
            errors++; $display("FAIL mid_reload: done=%b writes=%0d count=%0d want 1 5 5", done, write_count, words_loaded);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (mem_model[i] !== 32'h1234_5000 + 32'(i * 7)) begin
                errors++; $display("FAIL mid_addr%0d: got %h want %h", i, mem_model[i], 32'h1234_5000 + 32'(i * 7));
            end
        end
    endtask

    task automatic test_full();
        logic [31:0] sum;
        clear_model();
        sum = 32'd0;
        pulse_start();
        send_word(32'h0000_1000, 0);
        for (int i = 0; i < 4096; i++) begin
            send_word(32'hC0DE_0000 + 32'(i), 0);
            sum = sum + 32'hC0DE_0000 + 32'(i);
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_word(sum, 0);
`endif
        wait_final();
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL full_done: got %b want 1", done); end
        checks++; if (words_loaded !== 13'd4096) begin errors++; $display("FAIL full_count: got %0d want 4096", words_loaded); end
        checks++; if (last_waddr !== 12'd4095) begin errors++; $display("FAIL full_last: got %0d want 4095", last_waddr); end
        checks++; if (addr0_writes != 1 || write_count != 4096) begin errors++; $display("FAIL full_writes: addr0=%0d total=%0d want 1 4096", addr0_writes, write_count); end
        checks++; if (mem_model[4095] !== 32'hC0DE_0FFF) begin errors++; $display("FAIL full_data_last: got %h want c0de0fff", mem_model[4095]); end
        checks++; if (mem_model[2048] !== 32'hC0DE_0800) begin errors++; $display("FAIL full_data_mid: got %h want c0de0800", mem_model[2048]); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero();
        test_overflow();
`ifdef IMEM_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        test_reset_mid();
        test_full();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
